// File: rtl/cordic.sv
// cordic: iterative rotation-mode CORDIC producing cos/sin of a Q16.16 angle.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   angle    signed Q16.16 angle in radians, sampled on the start edge
//   opt      output select, sampled on the start edge
//            (00 cos only, 01 sin only, 1x both)
//   enable   level-sensitive start request / result hold
//   sin_out  signed Q16.16 sine
//   cos_out  signed Q16.16 cosine
//   done     result valid; held while enable stays high
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for enable; reduces angle into [-pi/2, pi/2]
// ROT   | one micro-rotation per cycle, plus one closing cycle
// FIN   | register (optionally negated) results, raise done
// DONE  | hold done until enable is seen low
module cordic #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] angle,
  input  logic [1:0]  opt,
  input  logic        enable,
  output logic [31:0] sin_out,
  output logic [31:0] cos_out,
  output logic        done
);

  localparam logic signed [31:0] PI      = 32'sd205887;
  localparam logic signed [31:0] HALF_PI = 32'sd102944;
  localparam logic signed [31:0] TWO_PI  = 32'sd411775;
  localparam logic signed [31:0] K_GAIN  = 32'sd39797;
  localparam logic [4:0]         ITER_L  = 5'(ITER);

  typedef enum logic [1:0] {IDLE, ROT, FIN, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic [4:0]         i_q, i_d;
  logic               neg_q, neg_d;
  logic [1:0]         opt_q, opt_d;
  logic [31:0]        cos_q, cos_d;
  logic [31:0]        sin_q, sin_d;
  logic               done_q, done_d;

  logic signed [31:0] angle_s;
  logic signed [31:0] z_wrap;
  logic signed [31:0] z_red;
  logic               neg_red;
  logic signed [31:0] x_sh;
  logic signed [31:0] y_sh;
  logic signed [31:0] atan_i;
  logic signed [31:0] x_res;
  logic signed [31:0] y_res;

  function automatic logic signed [31:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 32'sd51472;
      4'd1:    atan_lut = 32'sd30386;
      4'd2:    atan_lut = 32'sd16055;
      4'd3:    atan_lut = 32'sd8150;
      4'd4:    atan_lut = 32'sd4091;
      4'd5:    atan_lut = 32'sd2047;
      4'd6:    atan_lut = 32'sd1024;
      4'd7:    atan_lut = 32'sd512;
      4'd8:    atan_lut = 32'sd256;
      4'd9:    atan_lut = 32'sd128;
      4'd10:   atan_lut = 32'sd64;
      4'd11:   atan_lut = 32'sd32;
      4'd12:   atan_lut = 32'sd16;
      4'd13:   atan_lut = 32'sd8;
      4'd14:   atan_lut = 32'sd4;
      default: atan_lut = 32'sd2;
    endcase
  endfunction

  // Quadrant reduction: one 2pi wrap into [-pi, pi], then fold the outer
  // half-plane by pi and remember to negate both results.
  always_comb begin
    angle_s = signed'(angle);
    z_wrap  = angle_s;
    if (angle_s > PI) begin
      z_wrap = angle_s - TWO_PI;
    end else if (angle_s < -PI) begin
      z_wrap = angle_s + TWO_PI;
    end
    z_red   = z_wrap;
    neg_red = 1'b0;
    if (z_wrap > HALF_PI) begin
      z_red   = z_wrap - PI;
      neg_red = 1'b1;
    end else if (z_wrap < -HALF_PI) begin
      z_red   = z_wrap + PI;
      neg_red = 1'b1;
    end
  end

  always_comb begin
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    atan_i = atan_lut(i_q[3:0]);
    x_res  = neg_q ? -x_q : x_q;
    y_res  = neg_q ? -y_q : y_q;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    neg_d   = neg_q;
    opt_d   = opt_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          opt_d   = opt;
          z_d     = z_red;
          neg_d   = neg_red;
          x_d     = K_GAIN;
          y_d     = '0;
          i_d     = '0;
          state_d = ROT;
        end
      end
      ROT: begin
        // After the last micro-rotation i equals ITER; that closing cycle
        // only hands over to FIN.
        if (i_q == ITER_L) begin
          state_d = FIN;
        end else begin
          if (!z_q[31]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
          end
          i_d = i_q + 5'd1;
        end
      end
      FIN: begin
        cos_d   = (opt_q != 2'b01) ? x_res : '0;
        sin_d   = (opt_q != 2'b00) ? y_res : '0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!enable) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      neg_q   <= 1'b0;
      opt_q   <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      neg_q   <= neg_d;
      opt_q   <= opt_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      done_q  <= done_d;
    end
  end

  assign cos_out = cos_q;
  assign sin_out = sin_q;
  assign done    = done_q;

endmodule

// File: tb/tb_cordic.sv
module tb_cordic;

  logic        clk;
  logic        reset;
  logic [31:0] angle;
  logic [1:0]  opt;
  logic        enable;
  logic [31:0] sin_out;
  logic [31:0] cos_out;
  logic        done;

  int n_cmp;
  int n_bad;

  cordic #(.ITER(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .angle   (angle),
    .opt     (opt),
    .enable  (enable),
    .sin_out (sin_out),
    .cos_out (cos_out),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a computation and counts rising edges after the start edge
  // until done is seen; lat = -1 if done never rises within the budget.
  // If drop_at > 0, enable is released after that many post-start edges.
  task automatic run_op(input logic [31:0] a, input logic [1:0] o,
                        input int drop_at, output int lat);
    lat = -1;
    @(negedge clk);
    angle  = a;
    opt    = o;
    enable = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 40; n++) begin
      if (n == drop_at + 1 && drop_at > 0) begin
        @(negedge clk);
        enable = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_enable();
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    angle  = '0;
    opt    = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++;
    if (cos_out !== 32'd0) begin n_bad++; $display("FAIL reset_cos: got %0d want 0", $signed(cos_out)); end
    n_cmp++;
    if (sin_out !== 32'd0) begin n_bad++; $display("FAIL reset_sin: got %0d want 0", $signed(sin_out)); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_half_pi();
    int lat;
    int d;
    run_op(32'd102944, 2'b10, 0, lat);
    n_cmp++;
    if (lat !== 18) begin n_bad++; $display("FAIL hpi_latency: got %0d edges want 18", lat); end
    d = $signed(cos_out) - 0;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL hpi_cos: got %0d want 0+-16", $signed(cos_out)); end
    d = $signed(sin_out) - 65536;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL hpi_sin: got %0d want 65536+-16", $signed(sin_out)); end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL hpi_done_hold: got %b want 1", done); end
    release_enable();
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL hpi_done_drop: got %b want 0", done); end
    repeat (4) @(posedge clk);
    #1;
    d = $signed(sin_out) - 65536;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL hpi_sin_hold: got %0d want 65536+-16", $signed(sin_out)); end
  endtask

  task automatic test_quarter_pi();
    int lat;
    int d;
    fork
      run_op(32'd51472, 2'b10, 0, lat);
      begin
        // Inputs changing after the start edge must be ignored.
        @(posedge clk);
        @(negedge clk);
        angle = 32'd205887;
        opt   = 2'b00;
      end
    join
    d = $signed(cos_out) - 46341;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL qpi_cos: got %0d want 46341+-16", $signed(cos_out)); end
    d = $signed(sin_out) - 46341;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL qpi_sin: got %0d want 46341+-16", $signed(sin_out)); end
    release_enable();
  endtask

  task automatic test_zero_and_pi();
    int lat;
    int d;
    run_op(32'd0, 2'b10, 0, lat);
    d = $signed(cos_out) - 65536;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL zero_cos: got %0d want 65536+-16", $signed(cos_out)); end
    d = $signed(sin_out);
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL zero_sin: got %0d want 0+-16", $signed(sin_out)); end
    release_enable();
    run_op(32'd205887, 2'b11, 0, lat);
    d = $signed(cos_out) + 65536;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL pi_cos: got %0d want -65536+-16", $signed(cos_out)); end
    d = $signed(sin_out);
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL pi_sin: got %0d want 0+-16", $signed(sin_out)); end
    release_enable();
  endtask

  task automatic test_negative();
    int lat;
    int d;
    run_op(-32'sd102944, 2'b10, 0, lat);
    d = $signed(sin_out) + 65536;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL nhpi_sin: got %0d want -65536+-16", $signed(sin_out)); end
    d = $signed(cos_out);
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL nhpi_cos: got %0d want 0+-16", $signed(cos_out)); end
    release_enable();
    run_op(-32'sd137258, 2'b10, 0, lat);
    d = $signed(cos_out) + 32768;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL n2pi3_cos: got %0d want -32768+-16", $signed(cos_out)); end
    d = $signed(sin_out) + 56756;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL n2pi3_sin: got %0d want -56756+-16", $signed(sin_out)); end
    release_enable();
    // 3pi/2 wraps by -2pi to -pi/2.
    run_op(32'd308831, 2'b10, 0, lat);
    d = $signed(sin_out) + 65536;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL wrap_sin: got %0d want -65536+-16", $signed(sin_out)); end
    release_enable();
  endtask

  task automatic test_opt_select();
    int lat;
    int d;
    run_op(32'd51472, 2'b00, 0, lat);
    d = $signed(cos_out) - 46341;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL opt00_cos: got %0d want 46341+-16", $signed(cos_out)); end
    n_cmp++;
    if (sin_out !== 32'd0) begin n_bad++; $display("FAIL opt00_sin: got %0d want 0", $signed(sin_out)); end
    release_enable();
    run_op(32'd51472, 2'b01, 0, lat);
    n_cmp++;
    if (cos_out !== 32'd0) begin n_bad++; $display("FAIL opt01_cos: got %0d want 0", $signed(cos_out)); end
    d = $signed(sin_out) - 46341;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL opt01_sin: got %0d want 46341+-16", $signed(sin_out)); end
    release_enable();
  endtask

  task automatic test_reset_mid_rot();
    int lat;
    int d;
    // Outputs currently hold the opt=01 result (sin nonzero).
    @(negedge clk);
    angle  = 32'd102944;
    opt    = 2'b10;
    enable = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sin_out !== 32'd0) begin n_bad++; $display("FAIL mrst_sin: got %0d want 0", $signed(sin_out)); end
    n_cmp++;
    if (cos_out !== 32'd0) begin n_bad++; $display("FAIL mrst_cos: got %0d want 0", $signed(cos_out)); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL mrst_done: got %b want 0", done); end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL mrst_idle: got %b want 0", done); end
    run_op(32'd102944, 2'b10, 0, lat);
    n_cmp++;
    if (lat !== 18) begin n_bad++; $display("FAIL mrst_restart_latency: got %0d edges want 18", lat); end
    d = $signed(sin_out) - 65536;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL mrst_restart_sin: got %0d want 65536+-16", $signed(sin_out)); end
    release_enable();
  endtask

  task automatic test_enable_drop();
    int lat;
    int d;
    run_op(32'd51472, 2'b10, 4, lat);
    n_cmp++;
    if (lat !== 18) begin n_bad++; $display("FAIL edrop_latency: got %0d edges want 18", lat); end
    d = $signed(cos_out) - 46341;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL edrop_cos: got %0d want 46341+-16", $signed(cos_out)); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL edrop_pulse: got %b want 0", done); end
    d = $signed(sin_out) - 46341;
    n_cmp++;
    if (d < -16 || d > 16) begin n_bad++; $display("FAIL edrop_sin_hold: got %0d want 46341+-16", $signed(sin_out)); end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    enable = 1'b0;
    angle  = '0;
    opt    = '0;
    test_reset();
    test_half_pi();
    test_quarter_pi();
    test_zero_and_pi();
    test_negative();
    test_opt_select();
    test_reset_mid_rot();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic.md
Name: cordic

Overview:
- Iterative rotation-mode CORDIC that computes cosine and sine of a signed Q16.16 angle in radians.
- Results are signed Q16.16.
- One rotation micro-step per clock, behind a simple enable/done handshake.
- Used as a shared trig unit by datapath blocks that need cos/sin of a programmable angle.

Parameters:
- ITER, 16, number of CORDIC iterations (supported range 12..16; atan table holds 16 entries).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- angle  input  32  signed Q16.16 angle in radians; sampled at start.
- opt  input  2  output select; sampled at start. 00 = cos only, 01 = sin only, 10 = both, 11 = both.
- enable  input  1  start request / hold; level-sensitive.
- sin_out  output  32  signed Q16.16 sine result.
- cos_out  output  32  signed Q16.16 cosine result.
- done  output  1  result valid.

Behaviour:
- Reset: synchronous, active-high. Clears state to IDLE, sin_out = 0, cos_out = 0, done = 0. Reset has priority over everything, including mid-computation; any computation in progress is abandoned.
- States: IDLE, ROT, FIN, DONE.
- IDLE: on a rising edge with enable = 1, latch opt and perform quadrant reduction on angle:
  - If angle > PI: subtract 2PI. If angle < -PI: add 2PI (one correction only). Inputs beyond ±3PI give unspecified results.
  - Then, if z > HALF_PI: z -= PI and set neg = 1. If z < -HALF_PI: z += PI and set neg = 1. Otherwise neg = 0.
  - Initialise x = K, y = 0, i = 0. Go to ROT.
- ROT: each cycle, d = +1 if z >= 0, else -1.
  - x' = x - d*(y >>> i)
  - y' = y + d*(x >>> i)
  - z' = z - d*ATAN[i]
  - i' = i + 1
  - Shifts are arithmetic. After iteration ITER-1, go to FIN.
- FIN: register the results (negate both when neg = 1):
  - cos_out = x if opt selects cos, else 0.
  - sin_out = y if opt selects sin, else 0.
  - Set done = 1 and go to DONE.
- DONE: done stays 1 while enable = 1. When enable is sampled 0, done goes to 0 and the state returns to IDLE. Outputs hold their values until the next FIN or reset.
- Latency: done rises ITER+2 rising edges after the start edge (18 for ITER = 16). done is high for at least one cycle.
- enable dropping during ROT/FIN is ignored; the computation completes, and done then pulses exactly one cycle.
- A new start requires a return to IDLE, i.e. enable must be seen low once.
- angle and opt changes after the start edge have no effect.
- Constants (Q16.16):
  - PI = 205887, HALF_PI = 102944, 2PI = 411775, K = 39797.
  - ATAN[0..15] = 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2.
- Arithmetic: x, y, z are 32-bit signed internally. Magnitudes stay ≤ 1.65 in Q16.16, so no overflow. No rounding on shifts (truncation).
- Accuracy: |error| ≤ 16 LSB on each output versus ideal cos/sin×65536 for angles in [-PI, PI].

Test Plan:
- Reset 2 cycles, opt = 10, angle = 102944 (π/2), enable held until done → done exactly 18 edges after start; cos_out within 0±16; sin_out within 65536±16. Values stay stable after enable is dropped.
- angle = 51472 (π/4), opt = 10 → cos_out and sin_out both 46341±16.
- angle = 0 → cos_out 65536±16, sin_out 0±16. Then angle = 205887 (π) → cos_out -65536±16, sin_out 0±16 (reduction path).
- angle = -102944 → sin_out -65536±16. angle = -137258 (−2π/3) → cos_out -32768±16, sin_out -56756±16.
- opt = 00 with angle = 51472 → cos_out 46341±16, sin_out = 0. opt = 01 → cos_out = 0.
- Assert reset at ROT iteration 5 → next edge: outputs 0, done 0, state IDLE. A fresh start then completes normally. Separately, drop enable mid-ROT → done is a 1-cycle pulse with correct results.
